// File: rtl/dct_mac_sched.sv
// ---------------------------------------------------------------------------
// dct_mac_sched
// 8-point DCT multiply-accumulate scheduler. Collects eight unsigned samples,
// then for each output term k walks n = 0..7, fetching coefficient {k,n} from
// an external ROM, feeding a shared external (approximate) multiplier, and
// accumulating the signed products. Each finished X[k] is held on the output
// until the consumer accepts it; the next term starts the cycle after.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_data      sample offer (unsigned N bits)
//   in_ready              high in IDLE and LOAD only
//   coef_addr/coef_data   {k,n} ROM index / {sign, magnitude} returned same cycle
//   mul_en/mul_a/mul_b    shared multiplier request (sample x[n], |coef|)
//   mul_p                 unsigned product returned same cycle
//   out_valid/out_ready   result handshake
//   out_data/out_idx      signed 20-bit X[k] and its index k
//   busy                  high whenever not IDLE
// ---------------------------------------------------------------------------
module dct_mac_sched #(
    parameter int N   = 8,
    parameter int PTS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [N-1:0]   in_data,
    output logic           in_ready,
    output logic [5:0]     coef_addr,
    input  logic [N:0]     coef_data,
    output logic           mul_en,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic [2*N-1:0] mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [19:0]    out_data,
    output logic [2:0]     out_idx,
    output logic           busy
);

    localparam logic [2:0] LAST_IDX = 3'(PTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Sign-applies an unsigned product into the 20-bit accumulator domain.
    // The product is used exactly as returned by the approximate multiplier.
    function automatic logic signed [19:0] signed_term(input logic neg,
                                                       input logic [2*N-1:0] mag);
        logic signed [19:0] ext;
        ext = 20'(mag);
        signed_term = neg ? (20'sd0 - ext) : ext;
    endfunction

    state_t             state_r, state_nx;
    logic [2:0]         k_r, k_nx;
    logic [2:0]         n_r, n_nx;
    logic [2:0]         cnt_r, cnt_nx;
    logic signed [19:0] acc_r, acc_nx;
    logic [19:0]        out_data_r, out_data_nx;
    logic [2:0]         out_idx_r, out_idx_nx;
    logic [N-1:0]       x_r [PTS];
    logic               accept_s;
    logic               mac_s;
    logic signed [19:0] term_s;

    assign mac_s    = (state_r == ST_MAC);
    assign in_ready = (state_r == ST_IDLE) || (state_r == ST_LOAD);
    assign accept_s = in_valid && in_ready;
    assign term_s   = signed_term(coef_data[N], mul_p);

    assign mul_en    = mac_s;
    assign coef_addr = mac_s ? {k_r, n_r} : 6'd0;
    assign mul_a     = mac_s ? x_r[n_r] : {N{1'b0}};
    assign mul_b     = mac_s ? coef_data[N-1:0] : {N{1'b0}};
    assign out_valid = (state_r == ST_OUT);
    assign busy      = (state_r != ST_IDLE);
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            k_r        <= 3'd0;
            n_r        <= 3'd0;
            cnt_r      <= 3'd0;
            acc_r      <= 20'sd0;
            out_data_r <= 20'd0;
            out_idx_r  <= 3'd0;
        end else begin
            state_r    <= state_nx;
            k_r        <= k_nx;
            n_r        <= n_nx;
            cnt_r      <= cnt_nx;
            acc_r      <= acc_nx;
            out_data_r <= out_data_nx;
            out_idx_r  <= out_idx_nx;
        end
    end

    // Sample buffer, written in arrival order at the load counter position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PTS; i++) begin
                x_r[i] <= {N{1'b0}};
            end
        end else if (accept_s) begin
            x_r[cnt_r] <= in_data;
        end else begin
            x_r[cnt_r] <= x_r[cnt_r];
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nx    = state_r;
        k_nx        = k_r;
        n_nx        = n_r;
        cnt_nx      = cnt_r;
        acc_nx      = acc_r;
        out_data_nx = out_data_r;
        out_idx_nx  = out_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_nx   = cnt_r + 3'd1;
                    state_nx = ST_LOAD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    // Counter wraps to 0 on the last sample, ready for the next block.
                    cnt_nx = cnt_r + 3'd1;
                    if (cnt_r == LAST_IDX) begin
                        state_nx = ST_MAC;
                        k_nx     = 3'd0;
                        n_nx     = 3'd0;
                        acc_nx   = 20'sd0;
                    end else begin
                        state_nx = ST_LOAD;
                    end
                end else begin
                    state_nx = ST_LOAD;
                end
            end
            ST_MAC: begin
                if (n_r == LAST_IDX) begin
                    out_data_nx = 20'(acc_r + term_s);
                    out_idx_nx  = k_r;
                    acc_nx      = 20'sd0;
                    n_nx        = 3'd0;
                    state_nx    = ST_OUT;
                end else begin
                    acc_nx = acc_r + term_s;
                    n_nx   = n_r + 3'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (k_r == LAST_IDX) begin
                        k_nx     = 3'd0;
                        state_nx = ST_IDLE;
                    end else begin
                        k_nx     = k_r + 3'd1;
                        state_nx = ST_MAC;
                    end
                end else begin
                    state_nx = ST_OUT;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dct_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_dct_mac_sched
// Directed bench: models the coefficient ROM (selectable pattern) and an
// exact multiplier, loads hand-chosen sample blocks and compares each X[k]
// against hand-computed values, plus handshake, stall and reset behaviour.
// ---------------------------------------------------------------------------
module tb_dct_mac_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic [5:0]  coef_addr;
    logic [8:0]  coef_data;
    logic        mul_en;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_data;
    logic [2:0]  out_idx;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          coef_mode = 0;
    int          mon_cnt = 0;
    int          addr_bad = 0;
    int          rdy_bad = 0;
    logic [7:0]  samp [8];
    logic [19:0] expv [8];

    dct_mac_sched #(.N(8), .PTS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Coefficient ROM patterns:
    // 0: +255 everywhere, 1: -255 everywhere, 2: magnitude 1 with sign = n[0],
    // 3: +(k+1).
    always_comb begin
        case (coef_mode)
            0:       coef_data = 9'h0FF;
            1:       coef_data = 9'h1FF;
            2:       coef_data = {coef_addr[0], 8'd1};
            3:       coef_data = {6'd0, coef_addr[5:3]} + 9'd1;
            default: coef_data = 9'h000;
        endcase
    end

    assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

    // Counts MAC cycles since reset and checks the ROM address walks 0..63.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_cnt <= 0;
        end else if (mul_en === 1'b1) begin
            if (coef_addr !== mon_cnt[5:0]) addr_bad <= addr_bad + 1;
            mon_cnt <= mon_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_block(input bit hold);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("load_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data = samp[i];
        end
        @(negedge clk);
        if (hold) in_data = 8'd77;
        else in_valid = 1'b0;
        check("mac_in_ready", in_ready, 0);
    endtask

    task automatic collect(input int stall_k);
        int t;
        logic [19:0] held;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 40) begin
                if (in_ready !== 1'b0) rdy_bad++;
                @(negedge clk);
                t++;
            end
            check("out_latency", t, 8);
            check("out_idx", out_idx, k);
            check("out_data", out_data, expv[k]);
            if (k == stall_k) begin
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, held);
                    check("stall_idx", out_idx, k);
                    check("stall_mul_en", mul_en, 0);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (k < 7) begin
                check("next_mul_en", mul_en, 1);
                check("next_addr", coef_addr, (k + 1) * 8);
            end else begin
                check("end_busy", busy, 0);
            end
        end
    endtask

    initial begin
        int t;
        int base;
        int ov_bad;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_en", mul_en, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_coef_addr", coef_addr, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // All-zero samples, +255 coefficients
        coef_mode = 0;
        for (int i = 0; i < 8; i++) begin samp[i] = 8'd0; expv[i] = 20'd0; end
        load_block(1'b0);
        collect(-1);

        // Full-scale positive and negative
        for (int i = 0; i < 8; i++) begin samp[i] = 8'd255; expv[i] = 20'd520200; end
        load_block(1'b0);
        collect(-1);
        coef_mode = 1;
        for (int i = 0; i < 8; i++) expv[i] = -20'sd520200;
        load_block(1'b0);
        collect(-1);

        // Alternating sign by n, samples 1..8: 1-2+3-4+5-6+7-8 = -4
        coef_mode = 2;
        for (int i = 0; i < 8; i++) begin samp[i] = 8'(i + 1); expv[i] = -20'sd4; end
        base = mon_cnt;
        load_block(1'b0);
        collect(-1);
        check("mul_en_cycles", mon_cnt - base, 64);
        check("addr_sequence_bad", addr_bad, 0);

        // Coefficient k+1, samples 1..8 -> 36*(k+1); consumer stalls at k=3
        coef_mode = 3;
        for (int i = 0; i < 8; i++) expv[i] = 20'(36 * (i + 1));
        load_block(1'b0);
        collect(3);

        // in_valid held high throughout: 8 accepts, none until IDLE
        coef_mode = 0;
        for (int i = 0; i < 8; i++) expv[i] = 20'd9180;
        rdy_bad = 0;
        load_block(1'b1);
        collect(-1);
        check("hold_in_ready_bad", rdy_bad, 0);
        check("hold_idle_ready", in_ready, 1);
        @(negedge clk);
        check("ninth_accept_busy", busy, 1);
        in_valid = 1'b0;

        // Reset in the middle of k=2, n=4
        do_reset();
        for (int i = 0; i < 8; i++) samp[i] = 8'd255;
        load_block(1'b0);
        out_ready = 1'b1;
        t = 0;
        while (!(mul_en === 1'b1 && coef_addr === 6'd20) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_k2_n4", (t < 100) ? 1 : 0, 1);
        check("pre_rst_out_data", out_data, 20'd520200);
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mul_en", mul_en, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_idx", out_idx, 0);
        check("mid_rst_coef_addr", coef_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ov_bad++;
        end
        check("post_rst_no_valid", ov_bad, 0);
        coef_mode = 2;
        for (int i = 0; i < 8; i++) begin samp[i] = 8'(i + 1); expv[i] = -20'sd4; end
        load_block(1'b0);
        collect(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
